// File: rtl/mips_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package mips_pkg;

  localparam int WIDTH_DEF = 32;
  localparam logic [WIDTH_DEF-1:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } md_state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequenced multiplier (shift-add) or restoring divider.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  step_mode_t         mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // MUL: acc = {partial product, remaining multiplier bits}.
  // DIV: acc = {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    sum      = '0;
    trial    = '0;
    diff     = '0;
    acc_next = acc;
    if (mode == STEP_MUL) begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff  = trial[WIDTH-1:0] - operand;
      if (trial >= {1'b0, operand}) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO; stalls the pipeline on collisions.
module hilo_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall_md,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state, state_nx;
  step_mode_t         step_mode;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   divisor, dividend_raw, mag_a, mag_b, quo, rem, hi_fix, lo_fix;
  logic               op_div, neg_res, neg_rem, div0;
  logic               sign_a, sign_b, accept, last_iter;

  assign busy      = (state != IDLE);
  assign stall_md  = busy & (mf_req | start_mult | start_div);
  assign accept    = (state == IDLE) & (start_mult | start_div);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign sign_a    = signed_op & op_a[WIDTH-1];
  assign sign_b    = signed_op & op_b[WIDTH-1];
  assign mag_a     = sign_a ? -op_a : op_a;
  assign mag_b     = sign_b ? -op_b : op_b;

  always_comb begin
    step_mode = STEP_MUL;
    if (state == DIV) step_mode = STEP_DIV;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (step_mode),
    .acc      (acc),
    .operand  (divisor),
    .acc_next (acc_step)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_mult)     state_nx = MUL;
        else if (start_div) state_nx = DIV;
      end
      MUL, DIV: if (last_iter) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Iterations run on magnitudes; signs are re-applied here in the FIX cycle.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div0) begin
        hi_fix = dividend_raw;
        lo_fix = WIDTH'(DIV0_LO);
      end else begin
        hi_fix = neg_rem ? -rem : rem;
        lo_fix = neg_res ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      op_div       <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div0         <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt          <= '0;
        acc          <= {{WIDTH{1'b0}}, mag_a};
        divisor      <= mag_b;
        dividend_raw <= op_a;
        op_div       <= ~start_mult;
        neg_res      <= sign_a ^ sign_b;
        neg_rem      <= sign_a;
        div0         <= (op_b == '0);
      end else if (state == MUL || state == DIV) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        hi   <= hi_fix;
        lo   <= lo_fix;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl against a 64-bit arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start_mult, start_div, signed_op, mf_req;
  logic [W-1:0] op_a, op_b;
  logic         busy, stall_md, done;
  logic [W-1:0] hi, lo;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_mult (start_mult),
    .start_div  (start_div),
    .signed_op  (signed_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .mf_req     (mf_req),
    .busy       (busy),
    .stall_md   (stall_md),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input bit is_div, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] pv, qv, rv;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!is_div) begin
      pv = sa * sb;
      return pv;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    qv = sa / sb;
    rv = sa % sb;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic accept_op(input bit smult, input bit sdiv, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_mult = smult;
    start_div  = sdiv;
    signed_op  = sgn;
    op_a       = a;
    op_b       = b;
    if (smult && sdiv) $display("note: mult and div requested together, div is dropped");
    #1;
    check("stall_at_accept", stall_md, 0);
    @(posedge clk);
    #1;
    start_mult = 0;
    start_div  = 0;
    op_a       = $urandom;
    op_b       = $urandom;
    signed_op  = 1'($urandom_range(0, 1));
    check("busy_after_accept", busy, 1);
  endtask

  // Follows an accepted op through its 33 post-accept edges; optionally raises
  // mf_req from cycle mf_at and/or holds a queued div in execute.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int mf_at,
                           input bit qdiv, input bit qsgn,
                           input logic [31:0] qa, input logic [31:0] qb);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (mf_at > 0 && k >= mf_at) mf_req = 1;
      if (qdiv && k >= 2) begin
        start_div = 1;
        signed_op = (k == 33) ? qsgn : 1'($urandom_range(0, 1));
        op_a      = (k == 33) ? qa : $urandom;
        op_b      = (k == 33) ? qb : $urandom;
      end
      #1;
      if (k < 33) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        check({tag, "_hi_hold"}, hi, m_hi);
        check({tag, "_lo_hold"}, lo, m_lo);
        check({tag, "_stall"}, stall_md, mf_req | start_div);
      end else begin
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
        check({tag, "_stall_end"}, stall_md, 0);
      end
    end
    mf_req = 0;
    m_hi   = exp[63:32];
    m_lo   = exp[31:0];
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    if (qdiv) begin
      start_div = 0;
      op_a      = $urandom;
      op_b      = $urandom;
      check({tag, "_queued_accept"}, busy, 1);
    end
  endtask

  task automatic run_op(input string tag, input bit is_div, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b);
    accept_op(!is_div, is_div, sgn, a, b);
    wait_done(tag, ref_md(is_div, sgn, a, b), 0, 0, 0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, qa, qb;
    bit          is_div, sgn, qsgn;

    rst = 1; start_mult = 0; start_div = 0; signed_op = 0; mf_req = 0;
    op_a = '0; op_b = '0; m_hi = '0; m_lo = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall_md, 0);
    @(negedge clk);
    rst = 0;

    run_op("multu_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 0, 1, 32'hFFFF_FFFD, 32'h0000_0007);
    run_op("div_neg", 1, 1, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu", 1, 0, 32'd100, 32'd7);
    run_op("divu_zero", 1, 0, 32'd5, 32'd0);
    run_op("div_zero_s", 1, 1, 32'hFFFF_FFFB, 32'd0);
    run_op("div_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minmin", 0, 1, 32'h8000_0000, 32'h8000_0000);

    a = $urandom; b = $urandom;
    accept_op(1, 0, 1, a, b);
    wait_done("mf_stall", ref_md(0, 1, a, b), 3, 0, 0, '0, '0);

    @(negedge clk);
    mf_req = 1;
    #1;
    check("mf_idle_stall", stall_md, 0);
    check("mf_idle_hi", hi, m_hi);
    check("mf_idle_lo", lo, m_lo);
    mf_req = 0;

    a = $urandom; b = $urandom; qa = $urandom; qb = $urandom_range(1, 1000); qsgn = 1;
    accept_op(1, 0, 0, a, b);
    wait_done("b2b_mult", ref_md(0, 0, a, b), 0, 1, qsgn, qa, qb);
    wait_done("b2b_div", ref_md(1, qsgn, qa, qb), 0, 0, 0, '0, '0);

    a = $urandom; b = $urandom;
    accept_op(1, 1, 1, a, b);
    wait_done("both_start", ref_md(0, 1, a, b), 0, 0, 0, '0, '0);

    for (int i = 0; i < 16; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      a      = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), is_div, sgn, a, b);
    end

    accept_op(1, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst  = 0;
    m_hi = '0;
    m_lo = '0;
    run_op("post_rst", 0, 0, 32'd6, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequenced multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core. It replaces the single-cycle multiplier and the free-running HI/LO write path. It accepts mult/multu/div/divu from the execute stage and iterates one bit per cycle. It raises a stall to the hazard logic while any mfhi/mflo or new mul/div would collide with an operation still in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start_mult  input  1  execute-stage mult/multu valid (already squashed by flushE)
start_div  input  1  execute-stage div/divu valid (already squashed by flushE)
signed_op  input  1  1: mult/div; 0: multu/divu; sampled with start
op_a  input  WIDTH  forwarded rs operand (mux_AE output)
op_b  input  WIDTH  forwarded rt operand (mux_BE output)
mf_req  input  1  mfhi/mflo present in execute stage
busy  output  1  operation in flight (state != IDLE)
stall_md  output  1  stall request to hazard unit (holds F/D/E, bubbles M)
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register (remainder / product upper half)
lo  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, hi=0, lo=0, done=0, internal accumulators=0. Reset mid-operation abandons the operation with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE: start_mult → MUL; else start_div → DIV. Both asserted → mult wins and div is dropped (illegal per decoder; a bench assertion flags it). On the accept edge: latch magnitudes |op_a|, |op_b| (if signed_op), the result sign(s), and a div-by-zero flag. Clear counter and accumulators.
- MUL: shift-add, one multiplier bit per edge. 2·WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per edge. WIDTH+1-bit partial remainder.
- counter increments each MUL/DIV edge. At counter==WIDTH-1 the next edge → FIX.
- FIX: apply sign correction (two's complement negate). Product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign; quotient truncates toward zero. The FIX edge writes hi/lo, pulses done=1, → IDLE.
- Latency: accept edge E0. Iterations on E1..E_WIDTH. HI/LO write at E_(WIDTH+1). done high in the cycle after E_(WIDTH+1). For WIDTH=32: 33 edges after accept.
- Divide by zero (op_b==0, either signedness): run full latency; hi=op_a as given, lo=all ones. No exception.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- hi/lo change only on the FIX edge. They hold value otherwise, including across start/stall.
- busy = (state != IDLE), combinational from the state register.
- stall_md = busy & (mf_req | start_mult | start_div), combinational. mfhi/mflo in IDLE does not stall and reads current hi/lo. mfhi/mflo in the same cycle as the FIX edge stalls one cycle, then reads the new value.
- Start while busy: not accepted. stall_md holds the instruction in execute until IDLE, and it is accepted on the first IDLE cycle.
- Operands latched at accept. Later op_a/op_b changes are ignored.
- No mthi/mtlo support in this revision.

Decomposition:
- Shared package mips_pkg: state enum (IDLE, MUL, DIV, FIX); WIDTH default constant; DIV0_LO constant (all ones).
- One sub-module is natural: muldiv_step. It is a combinational single iteration (add-shift or subtract-compare-shift) over the accumulator, selected by mode. The FSM, counter, sign fixup and HI/LO registers stay in hilo_muldiv_ctrl.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF, signed_op=0 → after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done exactly one cycle; busy high for 33 cycles.
- mult −3 × 7 (0xFFFFFFFD, 0x00000007), signed_op=1 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div −7 / 2 signed → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 → lo=14, hi=2. divu 5 / 0 → lo=0xFFFFFFFF, hi=5.
- mf_req asserted 3 cycles after a mult accept → stall_md high until the FIX edge, low in the done cycle; hi/lo unchanged before the FIX edge. mf_req in IDLE → stall_md=0.
- Back-to-back: start_div held while busy with a mult → stall_md=1, div accepted on the first IDLE cycle; its operands are those present then. start_mult and start_div together in IDLE → MUL only.
- Assert rst at iteration 10 of a mult → hi=lo=0, busy=0 immediately; post-reset multu 6×7 → lo=42, hi=0.
